// File: rtl/proc_peak_search_if.sv
// proc_peak_search_if: frame control, sample beat and result handshakes for proc_peak_search.
// Optional build macro PROC_PEAK_MIN_EN adds the frame-minimum result signals.
interface proc_peak_search_if #(
  parameter int NDATA     = 128,
  parameter int NDATA_LOG = $clog2(NDATA),
  parameter int WIDTH     = NDATA_LOG + 1,
  parameter int NLANE     = 4
);
  logic                   start;
  logic [NLANE*WIDTH-1:0] din;
  logic                   dinValid;
  logic                   dinReady;
  logic [NDATA_LOG-1:0]   dout;
  logic [WIDTH-1:0]       doutVal;
  logic                   doutValid;
  logic                   doutReady;
  logic                   busy;
`ifdef PROC_PEAK_MIN_EN
  logic [NDATA_LOG-1:0]   doutMin;
  logic [WIDTH-1:0]       doutMinVal;

  modport master (output start, din, dinValid, doutReady,
                  input  dinReady, dout, doutVal, doutValid, busy, doutMin, doutMinVal);
  modport slave  (input  start, din, dinValid, doutReady,
                  output dinReady, dout, doutVal, doutValid, busy, doutMin, doutMinVal);
`else
  modport master (output start, din, dinValid, doutReady,
                  input  dinReady, dout, doutVal, doutValid, busy);
  modport slave  (input  start, din, dinValid, doutReady,
                  output dinReady, dout, doutVal, doutValid, busy);
`endif
endinterface

// File: rtl/proc_peak_search.sv
// proc_peak_search: streaming arg-max over a frame of NDATA samples, NLANE per beat.
// Stage 1 reduces each accepted beat with a lane tree; stage 2 keeps a running max over the frame.
// Ties always resolve to the lower sample index.
// Optional build macro PROC_PEAK_MIN_EN tracks the frame minimum alongside the maximum.
//
// state | meaning
// IDLE  | waiting for start, result registers hold the previous frame
// RUN   | accepting beats (dinReady=1)
// FLUSH | last beat in stage 1, folding it into the accumulator
// DONE  | result valid, waiting for doutReady
module proc_peak_search #(
  parameter int NDATA     = 128,
  parameter int NDATA_LOG = $clog2(NDATA),
  parameter int WIDTH     = NDATA_LOG + 1,
  parameter int NLANE     = 4
) (
  input logic              clk,
  input logic              rst,
  proc_peak_search_if.slave bus
);
  localparam int LANE_LOG = $clog2(NLANE);
  localparam int NBEAT    = NDATA / NLANE;
  localparam int BEAT_W   = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam int NNODE    = 2 * NLANE - 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t               state, stateNext;
  logic [BEAT_W-1:0]    beatCnt;
  logic                 accept, lastBeat, first;

  // Tree nodes: heap layout, leaves at NLANE-1.., left child covers lower lanes.
  logic [WIDTH-1:0]     maxV [NNODE];
  logic [NDATA_LOG-1:0] maxI [NNODE];
  logic                 s1Valid;
  logic [WIDTH-1:0]     s1Val, accVal, accValNext;
  logic [NDATA_LOG-1:0] s1Idx, accIdx, accIdxNext;
`ifdef PROC_PEAK_MIN_EN
  logic [WIDTH-1:0]     minV [NNODE];
  logic [NDATA_LOG-1:0] minI [NNODE];
  logic [WIDTH-1:0]     s1MinVal, accMinVal, accMinValNext;
  logic [NDATA_LOG-1:0] s1MinIdx, accMinIdx, accMinIdxNext;
`endif

  assign accept       = (state == RUN) && bus.dinValid;
  assign lastBeat     = (beatCnt == BEAT_W'(NBEAT - 1));
  assign bus.dinReady = (state == RUN);
  assign bus.busy     = (state != IDLE);
  assign bus.doutValid = (state == DONE);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (bus.start) stateNext = RUN;
      RUN:     if (accept && lastBeat) stateNext = FLUSH;
      FLUSH:   stateNext = DONE;
      DONE:    if (bus.doutReady) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Beat counter: cleared on start, advances on accepted beats, wraps at frame end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) beatCnt <= '0;
    else if (state == IDLE && bus.start) beatCnt <= '0;
    else if (accept) beatCnt <= lastBeat ? '0 : beatCnt + BEAT_W'(1);
  end

  // Lane tree over the current beat; right child wins only when strictly better
  always_comb begin
    for (int n = 0; n < NNODE; n++) begin
      maxV[n] = '0;
      maxI[n] = '0;
`ifdef PROC_PEAK_MIN_EN
      minV[n] = '0;
      minI[n] = '0;
`endif
    end
    for (int k = 0; k < NLANE; k++) begin
      maxV[NLANE-1+k] = bus.din[k*WIDTH +: WIDTH];
      maxI[NLANE-1+k] = (NDATA_LOG'(beatCnt) << LANE_LOG) | NDATA_LOG'(k);
`ifdef PROC_PEAK_MIN_EN
      minV[NLANE-1+k] = bus.din[k*WIDTH +: WIDTH];
      minI[NLANE-1+k] = (NDATA_LOG'(beatCnt) << LANE_LOG) | NDATA_LOG'(k);
`endif
    end
    for (int i = NLANE - 2; i >= 0; i--) begin
      if (maxV[2*i+2] > maxV[2*i+1]) begin
        maxV[i] = maxV[2*i+2];
        maxI[i] = maxI[2*i+2];
      end else begin
        maxV[i] = maxV[2*i+1];
        maxI[i] = maxI[2*i+1];
      end
`ifdef PROC_PEAK_MIN_EN
      if (minV[2*i+2] < minV[2*i+1]) begin
        minV[i] = minV[2*i+2];
        minI[i] = minI[2*i+2];
      end else begin
        minV[i] = minV[2*i+1];
        minI[i] = minI[2*i+1];
      end
`endif
    end
  end

  // Stage 1 register: per-beat winner
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1Valid <= 1'b0;
      s1Val   <= '0;
      s1Idx   <= '0;
`ifdef PROC_PEAK_MIN_EN
      s1MinVal <= '0;
      s1MinIdx <= '0;
`endif
    end else begin
      s1Valid <= accept;
      if (accept) begin
        s1Val <= maxV[0];
        s1Idx <= maxI[0];
`ifdef PROC_PEAK_MIN_EN
        s1MinVal <= minV[0];
        s1MinIdx <= minI[0];
`endif
      end
    end
  end

  // Stage 2 merge: earlier beats keep ties
  always_comb begin
    accValNext = accVal;
    accIdxNext = accIdx;
    if (s1Valid && (first || s1Val > accVal)) begin
      accValNext = s1Val;
      accIdxNext = s1Idx;
    end
`ifdef PROC_PEAK_MIN_EN
    accMinValNext = accMinVal;
    accMinIdxNext = accMinIdx;
    if (s1Valid && (first || s1MinVal < accMinVal)) begin
      accMinValNext = s1MinVal;
      accMinIdxNext = s1MinIdx;
    end
`endif
  end

  // Accumulator: cleared on start, first-flag seeds the minimum from beat 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accVal <= '0;
      accIdx <= '0;
      first  <= 1'b0;
`ifdef PROC_PEAK_MIN_EN
      accMinVal <= '0;
      accMinIdx <= '0;
`endif
    end else if (state == IDLE && bus.start) begin
      accVal <= '0;
      accIdx <= '0;
      first  <= 1'b1;
`ifdef PROC_PEAK_MIN_EN
      accMinVal <= '0;
      accMinIdx <= '0;
`endif
    end else begin
      accVal <= accValNext;
      accIdx <= accIdxNext;
      if (s1Valid) first <= 1'b0;
`ifdef PROC_PEAK_MIN_EN
      accMinVal <= accMinValNext;
      accMinIdx <= accMinIdxNext;
`endif
    end
  end

  // Result registers: loaded once per frame, held until the next frame completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.dout    <= '0;
      bus.doutVal <= '0;
`ifdef PROC_PEAK_MIN_EN
      bus.doutMin    <= '0;
      bus.doutMinVal <= '0;
`endif
    end else if (state == FLUSH) begin
      bus.dout    <= accIdxNext;
      bus.doutVal <= accValNext;
`ifdef PROC_PEAK_MIN_EN
      bus.doutMin    <= accMinIdxNext;
      bus.doutMinVal <= accMinValNext;
`endif
    end
  end
endmodule

// File: tb/tb_proc_peak_search.sv
// tb_proc_peak_search: directed frames plus randomized frames against a software arg-max model.
module tb_proc_peak_search;
  localparam int NDATA     = 128;
  localparam int NDATA_LOG = $clog2(NDATA);
  localparam int WIDTH     = NDATA_LOG + 1;
  localparam int NLANE     = 4;
  localparam int NBEAT     = NDATA / NLANE;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  proc_peak_search_if #(.NDATA(NDATA), .NDATA_LOG(NDATA_LOG), .WIDTH(WIDTH), .NLANE(NLANE)) bus ();

  proc_peak_search #(.NDATA(NDATA), .NDATA_LOG(NDATA_LOG), .WIDTH(WIDTH), .NLANE(NLANE)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int nChecks = 0;
  int nPass   = 0;

  logic [WIDTH-1:0]     samples [NDATA];
  logic [NDATA_LOG-1:0] expIdx;
  logic [WIDTH-1:0]     expVal;
  logic [NDATA_LOG-1:0] expMinIdx;
  logic [WIDTH-1:0]     expMinVal;
  bit                   expArmed = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
  endtask

  // Reference: plain scan in index order, strict compare keeps the lowest index on ties
  task automatic buildModel();
    expIdx = '0; expVal = samples[0];
    expMinIdx = '0; expMinVal = samples[0];
    for (int i = 1; i < NDATA; i++) begin
      if (samples[i] > expVal) begin expVal = samples[i]; expIdx = NDATA_LOG'(i); end
      if (samples[i] < expMinVal) begin expMinVal = samples[i]; expMinIdx = NDATA_LOG'(i); end
    end
  endtask

  function automatic logic [NLANE*WIDTH-1:0] packBeat(input int b);
    logic [NLANE*WIDTH-1:0] d;
    d = '0;
    for (int k = 0; k < NLANE; k++) d[k*WIDTH +: WIDTH] = samples[b*NLANE + k];
    return d;
  endfunction

  // Result compare on every cycle a result is presented
  always @(negedge clk) begin
    if (!rst && expArmed && bus.doutValid) begin
      check("dout", 32'(bus.dout), 32'(expIdx));
      check("doutVal", 32'(bus.doutVal), 32'(expVal));
`ifdef PROC_PEAK_MIN_EN
      check("doutMin", 32'(bus.doutMin), 32'(expMinIdx));
      check("doutMinVal", 32'(bus.doutMinVal), 32'(expMinVal));
`endif
    end
  end

  task automatic doFrame(input int gapPct, input int holdCycles);
    int  b;
    int  guard;
    bit  acc;
    buildModel();
    expArmed = 1'b1;
    @(posedge clk); #1; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    b = 0; guard = 0;
    while (b < NBEAT) begin
      bus.din      = packBeat(b);
      bus.dinValid = ($urandom_range(99) >= 32'(gapPct));
      @(negedge clk);
      acc = bus.dinValid && bus.dinReady;
      @(posedge clk); #1;
      if (acc) b++;
      guard++;
      if (guard > 5000) begin
        check("beat_timeout", 32'(b), 32'(NBEAT));
        break;
      end
    end
    bus.dinValid = 1'b0;
    @(negedge clk); check("lat_flush", 32'(bus.doutValid), 32'd0);
    @(negedge clk); check("lat_valid", 32'(bus.doutValid), 32'd1);
    for (int h = 0; h < holdCycles; h++) begin
      @(posedge clk); #1; bus.start = 1'b1; bus.dinValid = 1'b1;
      @(negedge clk);
      check("hold_dinReady", 32'(bus.dinReady), 32'd0);
      check("hold_busy", 32'(bus.busy), 32'd1);
      check("hold_valid", 32'(bus.doutValid), 32'd1);
    end
    @(posedge clk); #1; bus.start = 1'b0; bus.dinValid = 1'b0; bus.doutReady = 1'b1;
    @(posedge clk); #1; bus.doutReady = 1'b0;
    @(negedge clk);
    check("post_valid", 32'(bus.doutValid), 32'd0);
    check("post_busy", 32'(bus.busy), 32'd0);
    check("post_dout_hold", 32'(bus.dout), 32'(expIdx));
    check("post_val_hold", 32'(bus.doutVal), 32'(expVal));
  endtask

  initial begin
    int mode;
    bus.start = 1'b0; bus.din = '0; bus.dinValid = 1'b0; bus.doutReady = 1'b0;
    @(negedge clk);
    check("rst_dinReady", 32'(bus.dinReady), 32'd0);
    check("rst_doutValid", 32'(bus.doutValid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_dout", 32'(bus.dout), 32'd0);
    check("rst_doutVal", 32'(bus.doutVal), 32'd0);
    @(posedge clk); #1; rst = 1'b0;

    // Ramp
    for (int i = 0; i < NDATA; i++) samples[i] = WIDTH'(i);
    buildModel();
    check("model_ramp", 32'(expIdx), 32'd127);
    doFrame(0, 0);
    check("ramp_dout", 32'(bus.dout), 32'd127);
    check("ramp_val", 32'(bus.doutVal), 32'd127);

    // Tie between two equal peaks
    for (int i = 0; i < NDATA; i++) samples[i] = WIDTH'(5);
    samples[17] = WIDTH'(90); samples[93] = WIDTH'(90);
    doFrame(0, 0);
    check("tie_dout", 32'(bus.dout), 32'd17);
    check("tie_val", 32'(bus.doutVal), 32'd90);
`ifdef PROC_PEAK_MIN_EN
    check("tie_min", 32'(bus.doutMin), 32'd0);
    check("tie_minval", 32'(bus.doutMinVal), 32'd5);
`endif

    // Peak in lane 2 of the last beat, gappy input, slow consumer
    for (int i = 0; i < NDATA; i++) samples[i] = WIDTH'($urandom_range(199));
    samples[126] = WIDTH'(200);
    doFrame(50, 10);
    check("late_dout", 32'(bus.dout), 32'd126);
    check("late_val", 32'(bus.doutVal), 32'd200);

    // Reset mid-frame
    for (int i = 0; i < NDATA; i++) samples[i] = WIDTH'(200 + $urandom_range(55));
    expArmed = 1'b0;
    @(posedge clk); #1; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0; bus.dinValid = 1'b1;
    for (int b = 0; b < 20; b++) begin
      bus.din = packBeat(b);
      @(posedge clk); #1;
    end
    rst = 1'b1; bus.dinValid = 1'b0;
    @(negedge clk);
    check("abort_valid", 32'(bus.doutValid), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_dinReady", 32'(bus.dinReady), 32'd0);
    check("abort_dout", 32'(bus.dout), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < NDATA; i++) samples[i] = '0;
    samples[3] = WIDTH'(7);
    doFrame(0, 0);
    check("restart_dout", 32'(bus.dout), 32'd3);
    check("restart_val", 32'(bus.doutVal), 32'd7);

    // Back-to-back, second frame all zero
    for (int i = 0; i < NDATA; i++) samples[i] = WIDTH'($urandom_range(255));
    doFrame(0, 0);
    for (int i = 0; i < NDATA; i++) samples[i] = '0;
    doFrame(0, 0);
    check("zero_dout", 32'(bus.dout), 32'd0);
    check("zero_val", 32'(bus.doutVal), 32'd0);

    // Randomized frames
    for (int f = 0; f < 150; f++) begin
      mode = int'($urandom_range(2));
      for (int i = 0; i < NDATA; i++) begin
        if (mode == 0)      samples[i] = WIDTH'($urandom_range(255));
        else if (mode == 1) samples[i] = WIDTH'($urandom_range(3));
        else                samples[i] = WIDTH'(42);
      end
      if (mode == 2) samples[$urandom_range(NDATA-1)] = WIDTH'($urandom_range(255));
      doFrame(int'($urandom_range(60)), int'($urandom_range(3)));
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
